pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The parameter ADDR_W SHALL default to 16 and set the PC width in bits.
REQ-002 The parameter IMM_W SHALL default to 9 and set the signed branch-offset width in bits.
REQ-003 The parameter CNT_W SHALL default to 16 and set the taken-branch counter width.
REQ-004 The clock and reset SHALL be exactly: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  single rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 stall  input  1  freezes the PC, state and counter for this cycle.
REQ-008 br_valid  input  1  the current instruction is a branch.
REQ-009 br_reg  input  1  selects the target: 1 = register target, 0 = PC-relative immediate.
REQ-010 cond  input  3  branch condition code.
REQ-011 imm  input  IMM_W  signed word offset.
REQ-012 reg_target  input  ADDR_W  register branch target.
REQ-013 flags  input  3  {Z,V,N}.
REQ-014 halt  input  1  the current instruction is HLT.
REQ-015 pc  output  ADDR_W  registered current PC.
REQ-016 pc_plus2  output  ADDR_W  pc+2, combinational.
REQ-017 flush  output  1  a taken redirect occurs this cycle; kill the younger fetch.
REQ-018 halted  output  1  the FSM is in HALTED.
REQ-019 taken_cnt  output  CNT_W  saturating count of taken branches.

Function
REQ-020 Condition decode SHALL be:
- 000: ~Z
- 001: Z
- 010: ~Z&~N
- 011: N
- 100: Z|~N
- 101: N|Z
- 110: V
- 111: always
REQ-021 The signal taken SHALL equal br_valid & cond_true, evaluated combinationally from the current inputs.
REQ-022 The immediate target SHALL equal pc_plus2 + (sign-extend(imm) << 1), computed modulo 2^ADDR_W.
REQ-023 The register target SHALL equal reg_target with bit 0 forced to 0.
REQ-024 pc_plus2 SHALL wrap modulo 2^ADDR_W, so all-ones minus 1 plus 2 gives 0.
REQ-025 The FSM SHALL have two states, RUN and HALTED.
REQ-026 In RUN with stall=0, the PC update SHALL follow this priority:
- taken: pc <= target
- else halt: pc holds and state <= HALTED
- else: pc <= pc_plus2
REQ-027 A taken branch SHALL take priority over halt asserted in the same cycle, and the state SHALL remain RUN.
REQ-028 flush SHALL equal taken & ~stall & (state==RUN), with zero latency, and SHALL be asserted for exactly the update cycle.
REQ-029 When stall=1, pc, state and taken_cnt SHALL hold, flush SHALL be 0, and the branch SHALL NOT be consumed.
REQ-030 In HALTED, pc and taken_cnt SHALL hold, flush SHALL be 0, and all inputs except rst_n SHALL be ignored.
REQ-031 HALTED SHALL be exited only by reset.
REQ-032 taken_cnt SHALL increment by 1 on every cycle where flush=1.
REQ-033 taken_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-034 halted SHALL be registered and SHALL rise in the cycle after the halt instruction is accepted.

Reset
REQ-035 On rst_n low, the block SHALL asynchronously set pc=0, state=RUN, halted=0 and taken_cnt=0.
REQ-036 Reset asserted mid-branch or while HALTED SHALL take effect immediately, with no redirect retained.
REQ-037 flush SHALL be 0 while rst_n is low.
REQ-038 The first fetch after reset deassertion SHALL be at address 0.

Structure
REQ-039 A shared package SHALL define:
- the condition-code constants (COND_NEQ … COND_UNCOND)
- the RUN/HALTED state type
- the flag-index constants FLAG_Z=2, FLAG_V=1, FLAG_N=0
REQ-040 Condition evaluation SHALL be one combinational sub-module, branch_cond (inputs cond and flags, output cond_true).
REQ-041 The adders SHALL use the team's CLA adder instances, parametrised to ADDR_W.
REQ-042 The adders SHALL have all ports connected, with no multiply-driven nets.

Verification
REQ-043 Reset then 4 idle cycles -> pc sequence 0,2,4,6,8; flush=0.
REQ-044 pc=0x0010, br_valid=1, cond=001, Z=1, imm=9'h1FE -> next pc=0x000E, flush=1 for one cycle, taken_cnt=1; repeat with Z=0 -> pc=0x0012, flush=0.
REQ-045 pc=0x0020, br_reg=1, cond=111, reg_target=0x1235 -> next pc=0x1234; the same branch with stall=1 for 3 cycles -> pc holds at 0x0020 and flush=0 until stall drops.
REQ-046 halt=1 at pc=0x0040 -> pc stays 0x0040 and halted=1 the next cycle; further br_valid/cond=111 is ignored; rst_n pulse -> pc=0, halted=0.
REQ-047 Same-cycle halt=1, br_valid=1, cond=111, imm=4 -> pc=pc+10 and state stays RUN; a separate case with pc=0xFFFE and no branch -> next pc=0x0000.
REQ-048 CNT_W=2 with 5 consecutive taken branches -> taken_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_sequencer_pkg : condition codes, FSM state type and flag indices
// Rev 1.0
// ---------------------------------------------------------------------------
package pc_sequencer_pkg;

  localparam logic [2:0] COND_NEQ    = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_GT     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GE     = 3'b100;
  localparam logic [2:0] COND_LE     = 3'b101;
  localparam logic [2:0] COND_OV     = 3'b110;
  localparam logic [2:0] COND_UNCOND = 3'b111;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_sequencer_if : branch/control inputs and PC outputs of the sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int IMM_W  = 9,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              br_valid;
  logic              br_reg;
  logic [2:0]        cond;
  logic [IMM_W-1:0]  imm;
  logic [ADDR_W-1:0] reg_target;
  logic [2:0]        flags;
  logic              halt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus2;
  logic              flush;
  logic              halted;
  logic [CNT_W-1:0]  taken_cnt;

  modport master (
    output stall, br_valid, br_reg, cond, imm, reg_target, flags, halt,
    input  pc, pc_plus2, flush, halted, taken_cnt
  );

  modport slave (
    input  stall, br_valid, br_reg, cond, imm, reg_target, flags, halt,
    output pc, pc_plus2, flush, halted, taken_cnt
  );
endinterface
`default_nettype wire

// File: rtl/cla_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cla_adder : parallel-prefix carry-lookahead adder, WIDTH >= 2
// Rev 1.0
// ---------------------------------------------------------------------------
module cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g0;
  logic [WIDTH-1:0] w_gp;
  logic [WIDTH-1:0] w_pp;
  logic [WIDTH-1:0] w_gn;
  logic [WIDTH-1:0] w_pn;

  assign w_p = a ^ b;

  // Carry-in is folded into bit 0's generate so prefix G[i] is carry out of bit i.
  always_comb begin
    w_g0    = a & b;
    w_g0[0] = w_g0[0] | (w_p[0] & cin);
    w_gp    = w_g0;
    w_pp    = w_p;
    w_gn    = w_g0;
    w_pn    = w_p;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      w_gn = w_gp;
      w_pn = w_pp;
      for (int i = d; i < WIDTH; i++) begin
        w_gn[i] = w_gp[i] | (w_pp[i] & w_gp[i-d]);
        w_pn[i] = w_pp[i] & w_pp[i-d];
      end
      w_gp = w_gn;
      w_pp = w_pn;
    end
  end

  assign sum  = w_p ^ {w_gp[WIDTH-2:0], cin};
  assign cout = w_gp[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/pc_sequencer_branch_cond.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_cond : decodes the 3-bit condition code against {Z,V,N}
// Rev 1.0
// ---------------------------------------------------------------------------
module branch_cond
  import pc_sequencer_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       cond_true
);

  logic w_z;
  logic w_v;
  logic w_n;

  assign w_z = flags[FLAG_Z];
  assign w_v = flags[FLAG_V];
  assign w_n = flags[FLAG_N];

  always_comb begin
    cond_true = 1'b1;
    case (cond)
      COND_NEQ:    cond_true = ~w_z;
      COND_EQ:     cond_true = w_z;
      COND_GT:     cond_true = ~w_z & ~w_n;
      COND_LT:     cond_true = w_n;
      COND_GE:     cond_true = w_z | ~w_n;
      COND_LE:     cond_true = w_n | w_z;
      COND_OV:     cond_true = w_v;
      COND_UNCOND: cond_true = 1'b1;
      default:     cond_true = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_sequencer : PC update with conditional branches, halt FSM, taken counter
// Rev 1.0
// ---------------------------------------------------------------------------
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int IMM_W  = 9,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_sequencer_if.slave      bus
);

  localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(2);
  localparam logic [CNT_W-1:0]  c_cnt_one = CNT_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_flush;

  logic               w_cond_true;
  logic               w_taken;
  logic [ADDR_W-1:0]  w_pc_plus2;
  logic [ADDR_W-1:0]  w_offset;
  logic [ADDR_W-1:0]  w_imm_target;
  logic [ADDR_W-1:0]  w_target;
  logic               w_unused_cout_inc;
  logic               w_unused_cout_tgt;

  branch_cond u_branch_cond (
    .cond      (bus.cond),
    .flags     (bus.flags),
    .cond_true (w_cond_true)
  );

  assign w_taken = bus.br_valid & w_cond_true;

  cla_adder #(.WIDTH(ADDR_W)) u_pc_inc (
    .a    (r_pc),
    .b    (c_pc_step),
    .cin  (1'b0),
    .sum  (w_pc_plus2),
    .cout (w_unused_cout_inc)
  );

  // Word offset: sign-extend the immediate and scale by two bytes.
  assign w_offset = {{(ADDR_W-IMM_W-1){bus.imm[IMM_W-1]}}, bus.imm, 1'b0};

  cla_adder #(.WIDTH(ADDR_W)) u_br_target (
    .a    (w_pc_plus2),
    .b    (w_offset),
    .cin  (1'b0),
    .sum  (w_imm_target),
    .cout (w_unused_cout_tgt)
  );

  assign w_target = bus.br_reg ? (bus.reg_target & ~ADDR_W'(1)) : w_imm_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_flush     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!bus.stall) begin
          if (w_taken) begin
            w_pc_nxt  = w_target;
            w_flush   = 1'b1;
            w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + c_cnt_one;
          end else if (bus.halt) begin
            w_state_nxt = ST_HALTED;
          end else begin
            w_pc_nxt = w_pc_plus2;
          end
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign bus.pc        = r_pc;
  assign bus.pc_plus2  = w_pc_plus2;
  assign bus.flush     = w_flush & rst_n;
  assign bus.halted    = (r_state == ST_HALTED);
  assign bus.taken_cnt = r_cnt;

endmodule
`default_nettype wire
